note_period_detector: RTL and testbench

- Analysis end of the note synthesis path: takes the signed 32-bit audio sample stream produced by the waveform generators and recovers the note period in clock cycles, i.e. it recovers the `hz` count those generators use.
- Uses a hysteresis zero-crossing detector and a period counter.
- Publishes measured periods, note-present status and timeout events for pitch display and for self-check of the music-box sequencer.

---
 rtl/note_detect_pkg.sv | 15 +
 rtl/hysteresis_crossing.sv | 48 ++++
 rtl/note_period_detector.sv | 161 ++++++++++++++++
 tb/tb_note_period_detector.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/note_detect_pkg.sv
// Shared types and default constants for the note period detector.
package note_detect_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        TRACK   = 2'd2
    } state_e;

    localparam int unsigned WIDTH_DEF      = 32;
    localparam logic [31:0] HYST_DEF       = 32'd100000000;
    localparam logic [31:0] MIN_PERIOD_DEF = 32'd16;
    localparam logic [31:0] MAX_PERIOD_DEF = 32'd4000000;

endpackage

// File: rtl/hysteresis_crossing.sv
// Hysteresis rising-crossing detector: a low sample arms, a high sample
// while armed fires a combinational rise and disarms.
import note_detect_pkg::*;

module hysteresis_crossing #(
    parameter int unsigned      WIDTH = WIDTH_DEF,
    parameter logic [WIDTH-1:0] HYST  = WIDTH'(HYST_DEF)
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic                    clear,
    input  logic signed [WIDTH-1:0] sample_in,
    output logic                    rise
);

    localparam logic signed [WIDTH-1:0] HYST_POS = HYST;
    localparam logic signed [WIDTH-1:0] HYST_NEG = -HYST_POS;

    logic armed_q;
    logic armed_d;
    logic is_low;
    logic is_high;

    assign is_low  = (sample_in <= HYST_NEG);
    assign is_high = (sample_in >= HYST_POS);
    assign rise    = armed_q && is_high;

    // Clear dominates so a dropped enable or a timeout always disarms.
    always_comb begin
        armed_d = armed_q;
        if (clear) begin
            armed_d = 1'b0;
        end else if (is_low) begin
            armed_d = 1'b1;
        end else if (rise) begin
            armed_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            armed_q <= 1'b0;
        end else begin
            armed_q <= armed_d;
        end
    end

endmodule

// File: rtl/note_period_detector.sv
// Recovers the note period (in clocks) from a signed sample stream.
// Define PERIOD_AVG_EN to publish a 4-period running average instead of raw periods.
import note_detect_pkg::*;

module note_period_detector #(
    parameter int unsigned      WIDTH      = WIDTH_DEF,
    parameter logic [WIDTH-1:0] HYST       = WIDTH'(HYST_DEF),
    parameter logic [WIDTH-1:0] MIN_PERIOD = WIDTH'(MIN_PERIOD_DEF),
    parameter logic [WIDTH-1:0] MAX_PERIOD = WIDTH'(MAX_PERIOD_DEF)
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic                    enable,
    input  logic signed [WIDTH-1:0] sample_in,
    output logic [WIDTH-1:0]        period_out,
    output logic                    period_valid,
    output logic                    note_present,
    output logic                    timeout
);

    state_e           state_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] period_q;
    logic             valid_q;
    logic             present_q;
    logic             timeout_q;

    logic             rise;
    logic             at_limit;
    logic             timeout_evt;
    logic             accept;
    logic             publish;
    logic             xing_clear;
    logic [WIDTH-1:0] p_meas;
    logic [WIDTH-1:0] pub_value;

    hysteresis_crossing #(
        .WIDTH (WIDTH),
        .HYST  (HYST)
    ) u_crossing (
        .clock     (clock),
        .resetn    (resetn),
        .clear     (xing_clear),
        .sample_in (sample_in),
        .rise      (rise)
    );

    // Counter holds cycles since the last rise minus one, hence the +1.
    assign p_meas      = count_q + WIDTH'(1);
    assign at_limit    = (count_q == MAX_PERIOD - WIDTH'(1));
    assign timeout_evt = enable && (state_q != IDLE) && !rise && at_limit;
    assign accept      = enable && (state_q == TRACK) && rise && (p_meas >= MIN_PERIOD);
    assign xing_clear  = !enable || timeout_evt;

`ifdef PERIOD_AVG_EN
    logic [WIDTH-1:0] hist_q [4];
    logic [WIDTH+1:0] sum_q;
    logic [WIDTH+1:0] sum_d;
    logic [2:0]       fill_q;
    logic             avg_clear;

    // History restarts on every fresh acquisition, including from IDLE.
    assign avg_clear = !enable || (state_q == IDLE) || timeout_evt;
    assign sum_d     = sum_q - {2'b00, hist_q[3]} + {2'b00, p_meas};
    assign publish   = accept && (fill_q >= 3'd3);
    assign pub_value = WIDTH'(sum_d >> 2);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 4; i++) begin
                hist_q[i] <= '0;
            end
            sum_q  <= '0;
            fill_q <= '0;
        end else if (avg_clear) begin
            for (int i = 0; i < 4; i++) begin
                hist_q[i] <= '0;
            end
            sum_q  <= '0;
            fill_q <= '0;
        end else if (accept) begin
            hist_q[0] <= p_meas;
            for (int i = 1; i < 4; i++) begin
                hist_q[i] <= hist_q[i-1];
            end
            sum_q  <= sum_d;
            fill_q <= (fill_q == 3'd4) ? 3'd4 : fill_q + 3'd1;
        end
    end
`else
    assign publish   = accept;
    assign pub_value = p_meas;
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            count_q   <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            present_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            if (!enable) begin
                state_q   <= IDLE;
                count_q   <= '0;
                period_q  <= '0;
                present_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q <= ACQUIRE;
                        count_q <= '0;
                    end
                    ACQUIRE: begin
                        if (rise) begin
                            state_q <= TRACK;
                            count_q <= '0;
                        end else if (timeout_evt) begin
                            timeout_q <= 1'b1;
                            present_q <= 1'b0;
                            count_q   <= '0;
                        end else begin
                            count_q <= count_q + WIDTH'(1);
                        end
                    end
                    TRACK: begin
                        // A rise on the limit cycle still counts as a period.
                        if (rise) begin
                            count_q <= '0;
                            if (publish) begin
                                period_q  <= pub_value;
                                valid_q   <= 1'b1;
                                present_q <= 1'b1;
                            end
                        end else if (timeout_evt) begin
                            timeout_q <= 1'b1;
                            present_q <= 1'b0;
                            count_q   <= '0;
                            state_q   <= ACQUIRE;
                        end else begin
                            count_q <= count_q + WIDTH'(1);
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        count_q <= '0;
                    end
                endcase
            end
        end
    end

    assign period_out   = period_q;
    assign period_valid = valid_q;
    assign note_present = present_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_note_period_detector.sv
// Self-checking bench for note_period_detector against an event-level period model.
module tb_note_period_detector;

    localparam int HYST  = 100000000;
    localparam int MIN_P = 16;
    localparam int MAX_P = 3000;
    localparam int AMP   = 300000000;

    logic               clock = 1'b0;
    logic               resetn;
    logic               enable;
    logic signed [31:0] sample_in;
    logic [31:0]        period_out;
    logic               period_valid;
    logic               note_present;
    logic               timeout;

    always #5 clock = ~clock;

    note_period_detector #(
        .WIDTH      (32),
        .HYST       (32'd100000000),
        .MIN_PERIOD (32'd16),
        .MAX_PERIOD (32'd3000)
    ) dut (
        .clock        (clock),
        .resetn       (resetn),
        .enable       (enable),
        .sample_in    (sample_in),
        .period_out   (period_out),
        .period_valid (period_valid),
        .note_present (note_present),
        .timeout      (timeout)
    );

    int     n_cmp = 0;
    int     n_bad = 0;
    bit     check_on = 1'b0;
    longint edge_cnt = 0;
    longint last_valid_edge = -1;
    longint last_to_edge = -1;
    longint valid_seen = 0;
    longint to_seen = 0;

    // Model: cycle-indexed rise times rather than a counter.
    bit     m_active, m_locked, m_armed;
    longint m_cyc, m_start, m_last_rise;
    longint exp_period;
    bit     exp_valid, exp_present, exp_to;
    longint acc[$];

    task automatic check(input string nm, input longint got, input longint expv);
        n_cmp++;
        if (got != expv) begin
            n_bad++;
            $display("FAIL %s t=%0t got=%0d expected=%0d", nm, $time, got, expv);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_locked = 0; m_armed = 0;
        m_cyc = 0; m_start = 0; m_last_rise = 0;
        exp_period = 0; exp_valid = 0; exp_present = 0; exp_to = 0;
        acc.delete();
    endtask

    task automatic accept_period(input longint p);
`ifdef PERIOD_AVG_EN
        longint sm;
        acc.push_back(p);
        if (acc.size() > 4) void'(acc.pop_front());
        if (acc.size() == 4) begin
            sm = 0;
            foreach (acc[i]) sm += acc[i];
            exp_period = sm / 4;
            exp_valid = 1; exp_present = 1;
        end
`else
        exp_period = p;
        exp_valid = 1; exp_present = 1;
`endif
    endtask

    task automatic model_step(input bit en, input int s);
        bit rise, to_evt;
        exp_valid = 0; exp_to = 0; to_evt = 0;
        rise = m_armed && (s >= HYST);
        if (!en) begin
            m_active = 0; m_locked = 0;
            exp_period = 0; exp_present = 0;
            acc.delete();
        end else if (!m_active) begin
            m_active = 1; m_start = m_cyc + 1;
            acc.delete();
        end else if (rise) begin
            if (m_locked) begin
                if (m_cyc - m_last_rise >= MIN_P) accept_period(m_cyc - m_last_rise);
            end else begin
                m_locked = 1;
            end
            m_last_rise = m_cyc;
            m_start = m_cyc + 1;
        end else if (m_cyc - m_start == MAX_P - 1) begin
            exp_to = 1; exp_present = 0;
            m_locked = 0; to_evt = 1;
            m_start = m_cyc + 1;
            acc.delete();
        end
        if (!en || to_evt) m_armed = 0;
        else if (s <= -HYST) m_armed = 1;
        else if (rise) m_armed = 0;
        m_cyc++;
    endtask

    always @(posedge clock) begin
        #2;
        if (check_on) begin
            edge_cnt++;
            check("period_out", longint'(period_out), exp_period);
            check("period_valid", longint'(period_valid), longint'(exp_valid));
            check("note_present", longint'(note_present), longint'(exp_present));
            check("timeout", longint'(timeout), longint'(exp_to));
            check("valid_and_timeout", longint'(period_valid & timeout), 0);
            if (period_valid) begin valid_seen++; last_valid_edge = edge_cnt; end
            if (timeout) begin to_seen++; last_to_edge = edge_cnt; end
        end
    end

    task automatic drive_now(input bit en, input int s);
        enable = en;
        sample_in = s;
        model_step(en, s);
    endtask

    task automatic tick(input bit en, input int s);
        @(negedge clock);
        drive_now(en, s);
    endtask

    task automatic hold(input bit en, input int s, input int n);
        repeat (n) tick(en, s);
    endtask

    task automatic square(input int lo, input int hi, input int reps);
        repeat (reps) begin
            hold(1'b1, -AMP, lo);
            hold(1'b1, AMP, hi);
        end
    endtask

    function automatic int in_band();
        return int'($urandom_range(0, 2 * HYST - 2)) - (HYST - 1);
    endfunction

    function automatic int rand_lo();
        int r = int'($urandom_range(0, 9));
        if (r == 0) return in_band();
        if (r == 1) return -HYST;
        return -HYST - int'($urandom_range(0, 200000000));
    endfunction

    function automatic int rand_hi();
        int r = int'($urandom_range(0, 9));
        if (r == 0) return in_band();
        if (r == 1) return HYST;
        return HYST + int'($urandom_range(0, 200000000));
    endfunction

    longint v0, t0, en_edge;

    initial begin
        resetn = 1'b0; enable = 1'b0; sample_in = '0;
        model_reset();
        repeat (3) @(negedge clock);
        check("reset_period_out", longint'(period_out), 0);
        check("reset_period_valid", longint'(period_valid), 0);
        check("reset_note_present", longint'(note_present), 0);
        check("reset_timeout", longint'(timeout), 0);
        @(negedge clock);
        resetn = 1'b1; model_reset(); check_on = 1'b1; drive_now(1'b0, 0);
        hold(1'b0, 0, 3);

        // Square wave, period 2000
        v0 = valid_seen;
        square(1000, 1000, 5);
`ifdef PERIOD_AVG_EN
        check("square_valid_count", valid_seen - v0, 1);
`else
        check("square_valid_count", valid_seen - v0, 4);
`endif
        check("square_period", longint'(period_out), 2000);
        check("model_square_period", exp_period, 2000);
        check("square_present", longint'(note_present), 1);

        // Stuck high after tracking
        t0 = to_seen;
        hold(1'b1, AMP, MAX_P + 50);
        check("stuck_timeout_count", to_seen - t0, 1);
        check("stuck_timeout_delay", last_to_edge - last_valid_edge, MAX_P);
        check("stuck_present", longint'(note_present), 0);
        check("stuck_period_held", longint'(period_out), 2000);

        // In-band noise from a fresh acquisition
        hold(1'b0, 0, 2);
        v0 = valid_seen;
        @(negedge clock);
        en_edge = edge_cnt + 1;
        drive_now(1'b1, 50000000);
        for (int i = 0; i < MAX_P + 20; i++) tick(1'b1, (i % 2 == 0) ? -50000000 : 50000000);
        check("noise_valid_count", valid_seen - v0, 0);
        check("noise_timeout_delay", last_to_edge - en_edge, MAX_P);

        // Glitch: short periods below MIN_PERIOD are dropped
        square(1000, 1000, 6);
        square(4, 4, 1);
        v0 = valid_seen;
        square(4, 4, 40);
        check("glitch_valid_count", valid_seen - v0, 0);
        check("glitch_present", longint'(note_present), 1);
        square(1000, 1000, 5);
        check("post_glitch_period", longint'(period_out), 2000);

        // Enable dropped mid-track
        hold(1'b1, -AMP, 300);
        t0 = to_seen;
        tick(1'b0, -AMP);
        @(negedge clock);
        check("disable_period_out", longint'(period_out), 0);
        check("disable_present", longint'(note_present), 0);
        check("disable_no_timeout", to_seen - t0, 0);
        drive_now(1'b0, 0);

        // Asynchronous reset mid-period
        hold(1'b0, 0, 2);
        square(1000, 1000, 6);
        hold(1'b1, -AMP, 300);
        @(posedge clock);
        #3;
        check_on = 1'b0;
        resetn = 1'b0;
        #1;
        check("areset_period_out", longint'(period_out), 0);
        check("areset_period_valid", longint'(period_valid), 0);
        check("areset_note_present", longint'(note_present), 0);
        check("areset_timeout", longint'(timeout), 0);
        @(negedge clock);
        resetn = 1'b1; model_reset(); check_on = 1'b1; drive_now(1'b1, -AMP);

`ifdef PERIOD_AVG_EN
        // Averaging: periods 2000, 2000, 2004, 2004
        hold(1'b0, 0, 2);
        v0 = valid_seen;
        square(1000, 1000, 3);
        square(1004, 1000, 1);
        hold(1'b1, -AMP, 1004);
        hold(1'b1, AMP, 100);
        check("avg_valid_count", valid_seen - v0, 1);
        check("avg_period", longint'(period_out), 2002);
`endif

        // Randomized waves with boundary and in-band samples
        for (int seg = 0; seg < 20; seg++) begin
            bit en;
            int r, half_lo, half_hi, reps;
            en = ($urandom_range(0, 9) != 0);
            reps = int'($urandom_range(1, 2));
            r = int'($urandom_range(0, 3));
            if (r == 0) begin
                half_lo = int'($urandom_range(1, 9));
                half_hi = int'($urandom_range(1, 9));
            end else if (r == 3) begin
                half_lo = int'($urandom_range(1300, 1700));
                half_hi = int'($urandom_range(1300, 1700));
            end else begin
                half_lo = int'($urandom_range(10, 1200));
                half_hi = int'($urandom_range(10, 1200));
            end
            for (int k = 0; k < reps; k++) begin
                for (int i = 0; i < half_lo; i++) tick(en, rand_lo());
                for (int i = 0; i < half_hi; i++) tick(en, rand_hi());
            end
        end

        @(negedge clock);
        check_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
